ysyx_22050019_wb_sched: RTL and testbench

Writeback scheduler and scoreboard for the 32x64 integer register file.
- Shares the register file's single write port (wen/waddr/wdata) between NREQ writeback requesters (ALU, LSU, CSR) using round-robin arbitration.
- Tracks destination registers with outstanding writes so issue stalls on WAW.
- Flags RAW hazards on the two register-file read addresses.

---
 rtl/ysyx_22050019_pkg.sv | 17 +
 rtl/ysyx_22050019_rr_arb.sv | 46 ++++
 rtl/ysyx_22050019_wb_sched.sv | 95 +++++++++
 tb/tb_ysyx_22050019_wb_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_pkg.sv
// Shared definitions for the writeback scheduler: requester indices,
// register-file geometry and the packed writeback request.
package ysyx_22050019_pkg;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LSU    = 1;
  localparam int REQ_CSR    = 2;
  localparam int NREQ       = 3;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_22050019_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward,
// pointer moves past the winner only when the grant is taken.
module ysyx_22050019_rr_arb #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] g_idx;
  logic [CW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    g_idx = ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        g_idx = cand[PW-1:0];
      end
    end
    // grants are suppressed while in reset so nothing can be consumed
    if (!rst && found) gnt[g_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (g_idx == PW'(N - 1)) ? '0 : g_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_22050019_wb_sched.sv
// Writeback scheduler: shares the register-file write port between requesters,
// tracks outstanding destinations (WAW stall) and flags RAW hazards on reads.
module ysyx_22050019_wb_sched #(
  parameter int NREQ       = ysyx_22050019_pkg::NREQ,
  parameter int ADDR_WIDTH = ysyx_22050019_pkg::REG_ADDR_W,
  parameter int DATA_WIDTH = ysyx_22050019_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_rd,
  output logic                       iss_ready,
  input  logic [ADDR_WIDTH-1:0]      raddr1,
  input  logic [ADDR_WIDTH-1:0]      raddr2,
  output logic                       raw_hazard1,
  output logic                       raw_hazard2,
  output logic                       wen,
  output logic [ADDR_WIDTH-1:0]      waddr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       err_unexp
);

  import ysyx_22050019_pkg::*;

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREQ-1:0] gnt;
  logic            hs;
  wb_req_t         sel;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            iss_fire;
  logic            wr_live;

  ysyx_22050019_rr_arb #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (hs),
    .gnt     (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel.addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel.data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign wr_live = hs && (sel.addr != '0);

  // Stall looks at the current busy bit only; a same-cycle clear releases next cycle.
  assign iss_ready = !rst && ((iss_rd == '0) || !busy[iss_rd]);
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != '0);

  always_comb begin
    busy_nxt = busy;
    if (hs)       busy_nxt[sel.addr] = 1'b0;
    if (iss_fire) busy_nxt[iss_rd]   = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      wen       <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      err_unexp <= 1'b0;
    end else begin
      busy <= busy_nxt;
      wen  <= wr_live;
      if (wr_live) begin
        waddr <= sel.addr;
        wdata <= sel.data;
        if (!busy[sel.addr]) err_unexp <= 1'b1;
      end
    end
  end

  // The output-stage term covers the cycle after busy clears but before the write lands.
  assign raw_hazard1 = (raddr1 != '0) && (busy[raddr1] || (wen && (waddr == raddr1)));
  assign raw_hazard2 = (raddr2 != '0) && (busy[raddr2] || (wen && (waddr == raddr2)));

endmodule

// File: tb/tb_ysyx_22050019_wb_sched.sv
// Self-checking bench for the writeback scheduler: a cycle model predicts grants,
// stalls and hazards; expected writes are queued and matched against wen/waddr/wdata.
module tb_ysyx_22050019_wb_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req_valid;
  logic [2:0]   req_ready;
  logic [14:0]  req_addr;
  logic [191:0] req_data;
  logic         iss_valid;
  logic [4:0]   iss_rd;
  logic         iss_ready;
  logic [4:0]   raddr1, raddr2;
  logic         raw_hazard1, raw_hazard2;
  logic         wen;
  logic [4:0]   waddr;
  logic [63:0]  wdata;
  logic         err_unexp;

  ysyx_22050019_wb_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .iss_ready   (iss_ready),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .raw_hazard1 (raw_hazard1),
    .raw_hazard2 (raw_hazard2),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .err_unexp   (err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_busy   = '0;
  int          m_ptr    = 0;
  logic        m_wen    = 1'b0;
  logic [4:0]  m_waddr  = '0;
  logic        m_err    = 1'b0;
  int          last_g   = -1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic hz(input logic [4:0] r);
    return (r != 0) && (m_busy[r] || (m_wen && (m_waddr == r)));
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    req_valid[i]       = v;
    req_addr[i*5 +: 5] = a;
    req_data[i*64 +: 64] = d;
  endtask

  // One clock cycle: check at negedge against the model, then advance the model.
  task automatic cyc();
    wr_t        e;
    int         g;
    logic [2:0] exp_rdy;
    logic       exp_iss;
    logic [4:0] a;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("wen", wen, e.w);
      if (e.w) begin
        check_eq("waddr", waddr, e.a);
        check_eq("wdata", wdata, e.d);
      end
    end
    check_eq("err_unexp", err_unexp, m_err);
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    exp_rdy = (rst || g < 0) ? 3'b000 : 3'(1 << g);
    check_eq("req_ready", req_ready, exp_rdy);
    exp_iss = !rst && ((iss_rd == 0) || !m_busy[iss_rd]);
    check_eq("iss_ready", iss_ready, exp_iss);
    check_eq("raw_hazard1", raw_hazard1, hz(raddr1));
    check_eq("raw_hazard2", raw_hazard2, hz(raddr2));
    if (rst) begin
      last_g  = -1;
      m_busy  = '0;
      m_ptr   = 0;
      m_wen   = 1'b0;
      m_waddr = '0;
      m_err   = 1'b0;
      e = '{1'b0, 5'd0, 64'd0};
      exp_q.push_back(e);
    end else begin
      last_g = g;
      if (g >= 0) begin
        a = req_addr[g*5 +: 5];
        e = '{(a != 0), a, req_data[g*64 +: 64]};
        if (a != 0 && !m_busy[a]) m_err = 1'b1;
        m_busy[a] = 1'b0;
        m_ptr     = (g + 1) % 3;
        m_wen     = (a != 0);
        if (a != 0) m_waddr = a;
      end else begin
        e = '{1'b0, 5'd0, 64'd0};
        m_wen = 1'b0;
      end
      exp_q.push_back(e);
      if (iss_valid && exp_iss && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int alu_q[$];
    int lsu_q[$];
    int csr_q[$];
    int guard;

    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; raddr1 = '0; raddr2 = '0;
    @(posedge clk); #1;

    // reset: nothing granted or issued even with everything requesting
    req_valid = 3'b111; iss_valid = 1'b1; iss_rd = 5'd3;
    cyc(); cyc();
    rst = 1'b0; req_valid = '0; iss_valid = 1'b0;

    // issue x5, RAW on it, ALU writeback, hazard through the output stage
    iss_valid = 1'b1; iss_rd = 5'd5; cyc();
    iss_valid = 1'b0; raddr1 = 5'd5; cyc();
    set_req(0, 1'b1, 5'd5, 64'hDEAD); cyc();
    set_req(0, 1'b0, 5'd0, 64'd0); cyc();
    cyc();

    // WAW stall on x7 lasts until the cycle after the writeback handshake
    iss_valid = 1'b1; iss_rd = 5'd7; raddr2 = 5'd7; cyc();
    cyc(); cyc();
    set_req(1, 1'b1, 5'd7, 64'h7777_0000_1234_5678); cyc();
    set_req(1, 1'b0, 5'd0, 64'd0); cyc();
    iss_rd = 5'd0; cyc();
    iss_valid = 1'b0;
    set_req(2, 1'b1, 5'd7, 64'h77); cyc();
    set_req(2, 1'b0, 5'd0, 64'd0); cyc();

    // all three requesters contending: x10..x13 busy first
    for (int r = 10; r <= 13; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r); cyc();
    end
    iss_valid = 1'b0; raddr1 = 5'd12; raddr2 = 5'd13;
    alu_q = '{10, 13}; lsu_q = '{11}; csr_q = '{12};
    guard = 0;
    while ((alu_q.size() + lsu_q.size() + csr_q.size()) > 0 && guard < 12) begin
      if (alu_q.size() > 0) set_req(0, 1'b1, 5'(alu_q[0]), 64'hA000_0000 + 64'(alu_q[0]));
      else                  set_req(0, 1'b0, 5'd0, 64'd0);
      if (lsu_q.size() > 0) set_req(1, 1'b1, 5'(lsu_q[0]), 64'hB000_0000 + 64'(lsu_q[0]));
      else                  set_req(1, 1'b0, 5'd0, 64'd0);
      if (csr_q.size() > 0) set_req(2, 1'b1, 5'(csr_q[0]), 64'hC000_0000 + 64'(csr_q[0]));
      else                  set_req(2, 1'b0, 5'd0, 64'd0);
      cyc();
      if (last_g == 0 && alu_q.size() > 0) void'(alu_q.pop_front());
      if (last_g == 1 && lsu_q.size() > 0) void'(lsu_q.pop_front());
      if (last_g == 2 && csr_q.size() > 0) void'(csr_q.pop_front());
      guard++;
    end
    check_eq("rr_drain_cycles", 64'(guard), 64'd4);
    req_valid = '0; cyc();

    // write to x0 is accepted but never reaches the register file
    set_req(1, 1'b1, 5'd0, 64'hBAD); cyc();
    set_req(1, 1'b0, 5'd0, 64'd0); cyc();

    // write to a non-busy register raises the sticky error
    set_req(0, 1'b1, 5'd9, 64'h99); raddr1 = 5'd9; cyc();
    set_req(0, 1'b0, 5'd0, 64'd0); cyc();
    cyc(); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; cyc();

    // reset right after a handshake clears all scoreboard state and the pointer
    iss_valid = 1'b1; iss_rd = 5'd20; cyc();
    iss_rd = 5'd21; raddr1 = 5'd20; raddr2 = 5'd21; cyc();
    iss_valid = 1'b0;
    set_req(2, 1'b1, 5'd20, 64'h2020); cyc();
    set_req(2, 1'b0, 5'd0, 64'd0);
    rst = 1'b1; req_valid = 3'b111; req_addr = '0; cyc(); cyc();
    rst = 1'b0; cyc();
    req_valid = '0; cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
